alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised next-generation ALU for the MIPS datapath. It runs the single-cycle ops (add/sub/logic/slt/shift)
//  and iterative unsigned multiply/divide under a start/busy/done handshake. Results and status are registered.
//  The controller stalls the pipeline on busy and writes HI/LO from result_hi/ALU_result on done.
// PARAMETERS
//  WIDTH    32                  operand/result width (>=8)
//  SHAMT_W  $clog2(WIDTH)       shift-amount width
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous reset, active low
//  start          in   1        op request; sampled only while FSM is IDLE
//  ALU_ctrl       in   4        op code (see BEHAVIOUR)
//  ALU_operand_1  in   WIDTH    operand A
//  ALU_operand_2  in   WIDTH    operand B
//  shamnt         in   SHAMT_W  shift amount
//  busy           out  1        multi-cycle op in progress
//  done           out  1        one-cycle pulse: ALU_result/result_hi/ALU_status valid (held until next done)
//  ALU_result     out  WIDTH    result / product low / quotient
//  result_hi      out  WIDTH    product high / remainder; 0 for single-cycle ops
//  ALU_status     out  8        [7]zero [6]ovf [5]carry [4]neg [3]odd [2]div0 [1:0]=0
// BEHAVIOUR
//  Reset: async on rst_n=0 -> FSM IDLE; busy, done, ALU_result, result_hi, ALU_status, counter, all internal regs = 0.
//   Reset mid-operation aborts the op, drops busy at once, and gives no done.
//  Op codes: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 1010 xor, 0111 slt (signed, result 1/0),
//   1110 sll by shamnt, 1111 srl by shamnt, 1000 mul (unsigned), 1001 div (unsigned); any other code -> result 0.
//  FSM: IDLE -> (start & mul/div, B!=0 for div) -> CALC -> IDLE. A single-cycle op, div-by-0 or an undefined code stays IDLE.
//  Latency, with start sampled at edge N:
//   single-cycle/undefined/div0: outputs and done=1 after edge N; busy stays 0.
//   mul/div: operands load at edge N; busy=1 after edges N..N+WIDTH-1; commit and done=1 after edge N+WIDTH.
//   done lasts exactly one cycle. Outputs hold their last committed value until the next commit.
//  start while busy is ignored; no queueing. start in the done cycle is accepted (FSM is already IDLE).
//  Operands are captured at start; input changes during CALC do not affect the result.
//  mul: shift-add, 1 bit/cycle, 2*WIDTH product -> {result_hi, ALU_result}.
//  div: restoring, 1 bit/cycle -> ALU_result=quotient, result_hi=remainder.
//  div by zero: ALU_result = all ones, result_hi = operand_1, status[2]=1, done after 1 cycle.
//  Width rules: add/sub computed in WIDTH+1 bits.
//   carry[5] = bit WIDTH of A+B for add, borrow (A<B unsigned) for sub, 0 otherwise.
//  Flags computed on the committed result, in the same cycle as done:
//   zero[7] = (ALU_result==0), neg[4] = ALU_result[WIDTH-1], odd[3] = ALU_result[0].
//   ovf[6] add: A,B same sign and result sign differs.
//   ovf[6] sub: A,B differ in sign and result sign != A sign.
//   ovf[6] mul: result_hi != 0.
//   ovf[6] = 0 for all other ops.
//  Shift by shamnt >= WIDTH cannot occur (SHAMT_W bits); shamnt = 0 passes A through.
// TESTING (WIDTH=32)
//  add 7FFFFFFF+1 -> done next cycle, result 80000000, status 8'h50 (ovf, neg); add FFFFFFFF+1 -> 0, status 8'hA0.
//  sub 5-7 -> FFFFFFFE, carry/borrow=1, neg=1, ovf=0; slt -1,1 -> 1; srl 80000000 by 31 -> 1, odd=1.
//  mul 0001_0000 x 0001_0000 -> busy 32 cycles, done at cycle 32, result_hi=1, result=0, ovf=1, zero=1.
//  div 100/7 -> quotient 14, remainder 2, done at cycle 32; div 5/0 -> FFFFFFFF, hi=5, status[2]=1, 1-cycle done.
//  Toggle start and operands during a mul -> ignored and result unchanged; start in the done cycle -> new op accepted.
//  Assert rst_n=0 at cycle 10 of a div -> busy=0 and outputs 0 at once, no done; after release a new op runs normally.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle MIPS ALU: single-cycle arithmetic/logic/shift ops plus iterative
// unsigned shift-add multiply and restoring divide under a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         ALU_ctrl,
  input  logic [WIDTH-1:0]   ALU_operand_1,
  input  logic [WIDTH-1:0]   ALU_operand_2,
  input  logic [SHAMT_W-1:0] shamnt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALU_result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [7:0]         ALU_status
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1111;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t state, state_next;

  // Iteration registers: lo holds multiplier / dividend-becoming-quotient,
  // hi holds partial product / partial remainder, a_reg the other operand.
  logic [WIDTH-1:0] a_reg, hi_reg, lo_reg;
  logic             is_div;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic             accept_multi, commit;
  logic [WIDTH-1:0] c_res, c_hi;
  logic             c_ovf, c_carry, c_div0;
  logic [7:0]       c_status;

  assign add_sum  = {1'b0, ALU_operand_1} + {1'b0, ALU_operand_2};
  assign sub_diff = {1'b0, ALU_operand_1} - {1'b0, ALU_operand_2};

  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, a_reg};

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo_reg[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    accept_multi = 1'b0;
    commit       = 1'b0;
    c_res        = '0;
    c_hi         = '0;
    c_ovf        = 1'b0;
    c_carry      = 1'b0;
    c_div0       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          commit = 1'b1;
          case (ALU_ctrl)
            OP_ADD: begin
              c_res   = add_sum[WIDTH-1:0];
              c_carry = add_sum[WIDTH];
              c_ovf   = (ALU_operand_1[WIDTH-1] == ALU_operand_2[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != ALU_operand_1[WIDTH-1]);
            end
            OP_SUB: begin
              c_res   = sub_diff[WIDTH-1:0];
              c_carry = sub_diff[WIDTH];
              c_ovf   = (ALU_operand_1[WIDTH-1] != ALU_operand_2[WIDTH-1]) &&
                        (sub_diff[WIDTH-1] != ALU_operand_1[WIDTH-1]);
            end
            OP_AND: c_res = ALU_operand_1 & ALU_operand_2;
            OP_OR:  c_res = ALU_operand_1 | ALU_operand_2;
            OP_NOR: c_res = ~(ALU_operand_1 | ALU_operand_2);
            OP_XOR: c_res = ALU_operand_1 ^ ALU_operand_2;
            OP_SLT: c_res = {{(WIDTH-1){1'b0}},
                             ($signed(ALU_operand_1) < $signed(ALU_operand_2))};
            OP_SLL: c_res = ALU_operand_1 << shamnt;
            OP_SRL: c_res = ALU_operand_1 >> shamnt;
            OP_MUL: begin
              commit       = 1'b0;
              accept_multi = 1'b1;
              state_next   = S_CALC;
            end
            OP_DIV: begin
              if (ALU_operand_2 == '0) begin
                c_res  = '1;
                c_hi   = ALU_operand_1;
                c_div0 = 1'b1;
              end else begin
                commit       = 1'b0;
                accept_multi = 1'b1;
                state_next   = S_CALC;
              end
            end
            default: c_res = '0;
          endcase
        end
      end
      S_CALC: begin
        if (cnt == CNT_LAST) begin
          commit     = 1'b1;
          c_res      = step_lo;
          c_hi       = step_hi;
          c_ovf      = !is_div && (step_hi != '0);
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign c_status = {(c_res == '0), c_ovf, c_carry, c_res[WIDTH-1], c_res[0], c_div0, 2'b00};
  assign busy     = (state == S_CALC);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      ALU_result <= '0;
      result_hi  <= '0;
      ALU_status <= '0;
      a_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div     <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        ALU_result <= c_res;
        result_hi  <= c_hi;
        ALU_status <= c_status;
      end
      if (accept_multi) begin
        is_div <= (ALU_ctrl == OP_DIV);
        a_reg  <= (ALU_ctrl == OP_DIV) ? ALU_operand_2 : ALU_operand_1;
        lo_reg <= (ALU_ctrl == OP_DIV) ? ALU_operand_1 : ALU_operand_2;
        hi_reg <= '0;
        cnt    <= '0;
      end else if (state == S_CALC) begin
        hi_reg <= step_hi;
        lo_reg <= step_lo;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected results,
// a negedge monitor pops and compares them (value, hi, status, done cycle).
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    ALU_ctrl = '0;
  logic [W-1:0]  ALU_operand_1 = '0;
  logic [W-1:0]  ALU_operand_2 = '0;
  logic [4:0]    shamnt = '0;
  logic          busy, done;
  logic [W-1:0]  ALU_result, result_hi;
  logic [7:0]    ALU_status;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_ctrl(ALU_ctrl),
    .ALU_operand_1(ALU_operand_1), .ALU_operand_2(ALU_operand_2), .shamnt(shamnt),
    .busy(busy), .done(done), .ALU_result(ALU_result), .result_hi(result_hi),
    .ALU_status(ALU_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [7:0]   st;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, 64'(ALU_result), 64'(e.res));
        check({e.name, "_hi"},     64'(result_hi),  64'(e.hi));
        check({e.name, "_status"}, 64'(ALU_status), 64'(e.st));
        check({e.name, "_cycle"},  64'(cyc),        64'(e.cyc));
      end
    end
  end

  // Called at a negedge; drives one request for a single clock edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic [7:0] es, input bit multi, input string name);
    exp_t e;
    start = 1'b1; ALU_ctrl = op; ALU_operand_1 = a; ALU_operand_2 = b; shamnt = sh;
    e.res = er; e.hi = eh; e.st = es; e.name = name;
    e.cyc = cyc + 1 + (multi ? W : 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'(multi));
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    check("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [4:0] sh, input logic [W-1:0] er, input logic [W-1:0] eh,
                     input logic [7:0] es, input bit multi, input string name);
    @(negedge clk);
    issue(op, a, b, sh, er, eh, es, multi, name);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),       64'(0));
    check("rst_done",   64'(done),       64'(0));
    check("rst_result", 64'(ALU_result), 64'(0));
    check("rst_hi",     64'(result_hi),  64'(0));
    check("rst_status", 64'(ALU_status), 64'(0));
    rst_n = 1'b1;

    run(4'b0010, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 32'h0, 8'h50, 0, "add_ovf");
    run(4'b0010, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         32'h0, 8'hA0, 0, "add_carry");
    run(4'b0110, 32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 32'h0, 8'h30, 0, "sub_borrow");
    run(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 32'h0, 8'h70, 0, "sub_ovf");
    run(4'b0111, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         32'h0, 8'h08, 0, "slt");
    run(4'b1111, 32'h8000_0000, 32'h0,         5'd31, 32'h1,         32'h0, 8'h08, 0, "srl31");
    run(4'b1110, 32'h3,         32'h0,         5'd4,  32'h30,        32'h0, 8'h00, 0, "sll4");
    run(4'b1110, 32'h1234_5679, 32'h0,         5'd0,  32'h1234_5679, 32'h0, 8'h08, 0, "sll0");
    run(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 32'h0, 8'h10, 0, "and");
    run(4'b0001, 32'h0F,        32'hF0,        5'd0,  32'hFF,        32'h0, 8'h08, 0, "or");
    run(4'b1100, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 32'h0, 8'h18, 0, "nor");
    run(4'b1010, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 5'd0,  32'h5A5A_5A5A, 32'h0, 8'h00, 0, "xor");
    run(4'b0011, 32'h5,         32'h9,         5'd3,  32'h0,         32'h0, 8'h80, 0, "undef");
    run(4'b1001, 32'd5,         32'd0,         5'd0,  32'hFFFF_FFFF, 32'd5, 8'h1C, 0, "div0");
    run(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h1, 32'hFFFF_FFFE, 8'h48, 1, "mul_max");
    run(4'b1001, 32'hFFFF_FFFF, 32'd10,        5'd0,  32'h1999_9999, 32'd5, 8'h08, 1, "div_max");

    // Start and operand changes during a multiply must be ignored.
    @(negedge clk);
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 32'h1, 8'hC0, 1, "mul_toggle");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = ~start;
      ALU_ctrl = 4'b0010;
      ALU_operand_1 = 32'h1111_0000 + 32'(i);
      ALU_operand_2 = 32'h0000_2222 * 32'(i + 1);
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // A request presented during the done cycle is accepted.
    @(negedge clk);
    issue(4'b1001, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 8'h00, 1, "div_100_7");
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("div_done_seen", 64'(seen), 64'(1));
    issue(4'b0010, 32'd2, 32'd3, 5'd0, 32'd5, 32'd0, 8'h08, 0, "add_in_done");
    drain();

    // Reset in the middle of a divide aborts it with no done.
    @(negedge clk);
    issue(4'b1001, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 8'h00, 1, "div_abort");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_busy",   64'(busy),       64'(0));
    check("abort_done",   64'(done),       64'(0));
    check("abort_result", 64'(ALU_result), 64'(0));
    check("abort_hi",     64'(result_hi),  64'(0));
    check("abort_status", 64'(ALU_status), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run(4'b1000, 32'd6, 32'd7, 5'd0, 32'd42, 32'd0, 8'h00, 1, "mul_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
